mem_arbiter: RTL and testbench
==============================

Name: mem_arbiter

Overview:
- Shares the single main-memory port between the instruction-cache refill path and the data-cache refill/writeback path.
- Transfers one cache line per grant as a burst of BEATS words.
- Sits between the two caches and external memory.
- Cache stall signals to the control-flow unit are derived by the caches from their done pulses; this block only sequences and arbitrates.

Parameters:
- ADDR_W, 32, byte-address width
- DATA_W, 32, word width per beat
- BEATS, 4, words per cache line (power of 2, ≥2)

Ports:
- clk_i  in  1  clock
- rst_n_i  in  1  reset, asynchronous, active-low
- ic_req_i  in  1  icache line-read request; held until ic_done_o
- ic_addr_i  in  ADDR_W  icache miss address
- ic_rdata_o  out  DATA_W  read beat data to icache
- ic_valid_o  out  1  ic_rdata_o valid this cycle
- ic_beat_o  out  $clog2(BEATS)  beat index of current icache beat
- ic_done_o  out  1  one-cycle pulse, icache line complete
- dc_req_i  in  1  dcache request; held until dc_done_o
- dc_we_i  in  1  1 = line writeback, 0 = line refill
- dc_addr_i  in  ADDR_W  dcache line address
- dc_wdata_i  in  DATA_W  write data for beat dc_beat_o (combinational lookup by dcache)
- dc_rdata_o  out  DATA_W  read beat data to dcache
- dc_valid_o  out  1  dc_rdata_o valid (reads only)
- dc_beat_o  out  $clog2(BEATS)  current dcache beat index
- dc_done_o  out  1  one-cycle pulse, dcache line complete
- mem_req_o  out  1  memory beat request
- mem_we_o  out  1  memory write
- mem_addr_o  out  ADDR_W  beat byte address
- mem_wdata_o  out  DATA_W  write data
- mem_rdata_i  in  DATA_W  read data, valid with mem_ack_i
- mem_ack_i  in  1  beat accepted/completed

Behaviour:
- Reset (async, rst_n_i low): state IDLE, beat counter 0, all outputs 0; last-grant flag = ICACHE. Reset mid-burst aborts the burst immediately; no done pulse is issued.
- States: IDLE, GNT_I, GNT_D, DONE.
- IDLE: sample requests at the clock edge.
  - dc_req_i → GNT_D.
  - else ic_req_i → GNT_I.
  - Fixed priority: dcache wins ties, because the memory stage stall dominates.
- Grant latency: mem_req_o is high the cycle after the request is first seen in IDLE.
- GNT_x:
  - mem_req_o = 1; mem_we_o = dc_we_i latched at grant (always 0 for icache).
  - mem_addr_o = {latched_addr[ADDR_W-1:OFF], beat, 0s}, where OFF = $clog2(BEATS*DATA_W/8). Low address bits are forced to zero; the burst always starts at beat 0.
  - mem_wdata_o = dc_wdata_i.
  - On mem_ack_i: pulse x_valid_o with mem_rdata_i (reads only), then increment beat.
  - An ack on the same cycle as mem_req_o first rises is legal.
  - On ack with beat == BEATS-1: beat wraps to 0, go to DONE.
- DONE:
  - mem_req_o = 0.
  - Pulse x_done_o for exactly one cycle, then return to IDLE.
  - No grant in DONE, so the next grant is ≥2 cycles after the last ack. The requester deasserts req on the cycle after done.
- Requests are not cancellable: deassertion of req mid-burst is ignored and the burst completes.
- Latched address and we do not change during a burst.
- Beat outputs: x_beat_o shows the counter only while x is granted; otherwise 0.
- No ack: state holds indefinitely (no timeout).
- A request for the other cache arriving mid-burst waits in IDLE arbitration.

Optional Feature:
- MEM_ARB_RR_EN defined: round-robin arbitration.
  - When both requests are seen in IDLE, grant the cache not recorded in the last-grant flag.
  - The flag updates on each grant.
  - Flag reset value is ICACHE, so the first tie goes to dcache.
- MEM_ARB_RR_EN undefined: fixed dcache priority; the last-grant flag is not implemented.

Decomposition:
- Package mem_arb_pkg holds:
  - arb_state_t enum {IDLE, GNT_I, GNT_D, DONE}
  - requester_t enum {REQ_I, REQ_D}
  - default ADDR_W/DATA_W/BEATS localparams
- No sub-module: the grant pick, beat counter and FSM fit in one module.

Test Plan:
- ic_req_i = 1, ic_addr_i = 0x0000_1238, ack every cycle → mem_addr_o = 0x1230, 0x1234, 0x1238, 0x123C; 4 ic_valid_o pulses; ic_done_o one cycle after the 4th ack; mem_req_o low in DONE.
- dc_req_i = 1, dc_we_i = 1, dc_addr_i = 0x2000, dc_wdata_i = 0xA0+beat → mem_we_o = 1, mem_wdata_o = 0xA0..0xA3 at 0x2000..0x200C; dc_valid_o never high.
- ic_req_i and dc_req_i asserted in the same cycle, held → dcache granted first; icache granted ≥2 cycles after the dcache's last ack. With MEM_ARB_RR_EN, a second simultaneous pair is granted to icache first.
- Ack stalls (ack on cycles 1, 4, 5, 9) → address holds between acks; exactly 4 beats; done once.
- rst_n_i low after 2 beats of an icache burst → all outputs 0 asynchronously; after release, a new ic_req_i restarts at beat 0 with the base address.
- ic_req_i dropped after beat 1 → burst still completes 4 beats and ic_done_o pulses.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared types and default geometry for the main-memory arbiter.
package mem_arb_pkg;

  localparam int ADDR_W_DEF = 32;
  localparam int DATA_W_DEF = 32;
  localparam int BEATS_DEF  = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GNT_I = 2'd1,
    GNT_D = 2'd2,
    DONE  = 2'd3
  } arb_state_t;

  typedef enum logic {
    REQ_I = 1'b0,
    REQ_D = 1'b1
  } requester_t;

endpackage

// File: rtl/mem_arbiter.sv
// Arbitrates the single memory port between icache refills and dcache refill/writeback,
// one line burst per grant. Define MEM_ARB_RR_EN for round-robin tie-breaking.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF,
  parameter int BEATS  = BEATS_DEF
) (
  input  logic                     clk_i,
  input  logic                     rst_n_i,
  input  logic                     ic_req_i,
  input  logic [ADDR_W-1:0]        ic_addr_i,
  output logic [DATA_W-1:0]        ic_rdata_o,
  output logic                     ic_valid_o,
  output logic [$clog2(BEATS)-1:0] ic_beat_o,
  output logic                     ic_done_o,
  input  logic                     dc_req_i,
  input  logic                     dc_we_i,
  input  logic [ADDR_W-1:0]        dc_addr_i,
  input  logic [DATA_W-1:0]        dc_wdata_i,
  output logic [DATA_W-1:0]        dc_rdata_o,
  output logic                     dc_valid_o,
  output logic [$clog2(BEATS)-1:0] dc_beat_o,
  output logic                     dc_done_o,
  output logic                     mem_req_o,
  output logic                     mem_we_o,
  output logic [ADDR_W-1:0]        mem_addr_o,
  output logic [DATA_W-1:0]        mem_wdata_o,
  input  logic [DATA_W-1:0]        mem_rdata_i,
  input  logic                     mem_ack_i
);

  localparam int BW   = $clog2(BEATS);
  localparam int OFF  = $clog2(BEATS * DATA_W / 8);
  localparam int WOFF = $clog2(DATA_W / 8);

  arb_state_t          r_state;
  requester_t          r_owner;
  logic [BW-1:0]       r_beat;
  logic [ADDR_W-1:OFF] r_line;
  logic                r_we;

  logic                w_pick_d;
  logic                w_gnt_i;
  logic                w_gnt_d;
  logic                w_gnt;
  logic [ADDR_W-1:0]   w_base;
  logic [ADDR_W-1:0]   w_beat_off;
  logic                w_unused_addr_bits;

  // Line offset bits are discarded: every burst starts at beat 0 of the line.
  assign w_unused_addr_bits = ^{ic_addr_i[OFF-1:0], dc_addr_i[OFF-1:0]};

`ifdef MEM_ARB_RR_EN
  requester_t r_last;

  always_comb begin
    if (dc_req_i && ic_req_i) w_pick_d = (r_last == REQ_I);
    else                      w_pick_d = dc_req_i;
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_last <= REQ_I;
    end else if (r_state == IDLE && (dc_req_i || ic_req_i)) begin
      r_last <= w_pick_d ? REQ_D : REQ_I;
    end
  end
`else
  // The memory-stage stall dominates, so the dcache always wins a tie.
  always_comb begin
    w_pick_d = dc_req_i;
  end
`endif

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_state <= IDLE;
      r_owner <= REQ_I;
      r_beat  <= '0;
      r_line  <= '0;
      r_we    <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (dc_req_i || ic_req_i) begin
            r_beat <= '0;
            if (w_pick_d) begin
              r_state <= GNT_D;
              r_owner <= REQ_D;
              r_line  <= dc_addr_i[ADDR_W-1:OFF];
              r_we    <= dc_we_i;
            end else begin
              r_state <= GNT_I;
              r_owner <= REQ_I;
              r_line  <= ic_addr_i[ADDR_W-1:OFF];
              r_we    <= 1'b0;
            end
          end
        end
        GNT_I, GNT_D: begin
          if (mem_ack_i) begin
            r_beat <= r_beat + 1'b1;
            if (r_beat == BW'(BEATS - 1)) r_state <= DONE;
          end
        end
        DONE:    r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

  assign w_gnt_i    = (r_state == GNT_I);
  assign w_gnt_d    = (r_state == GNT_D);
  assign w_gnt      = w_gnt_i | w_gnt_d;
  assign w_base     = {r_line, {OFF{1'b0}}};
  assign w_beat_off = ADDR_W'(r_beat) << WOFF;

  assign mem_req_o   = w_gnt;
  assign mem_we_o    = w_gnt_d & r_we;
  assign mem_addr_o  = w_gnt ? (w_base | w_beat_off) : '0;
  assign mem_wdata_o = mem_we_o ? dc_wdata_i : '0;

  assign ic_valid_o = w_gnt_i & mem_ack_i;
  assign ic_rdata_o = ic_valid_o ? mem_rdata_i : '0;
  assign ic_beat_o  = w_gnt_i ? r_beat : '0;
  assign ic_done_o  = (r_state == DONE) && (r_owner == REQ_I);

  assign dc_valid_o = w_gnt_d & ~r_we & mem_ack_i;
  assign dc_rdata_o = dc_valid_o ? mem_rdata_i : '0;
  assign dc_beat_o  = w_gnt_d ? r_beat : '0;
  assign dc_done_o  = (r_state == DONE) && (r_owner == REQ_D);

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: line-level reference model, random memory acks,
// decoupled monitor. Honours MEM_ARB_RR_EN for the expected grant order.
module tb_mem_arbiter;

  localparam int BEATS = 4;
`ifdef MEM_ARB_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic        clk_i = 1'b0;
  logic        rst_n_i;
  logic        ic_req_i;
  logic [31:0] ic_addr_i;
  logic [31:0] ic_rdata_o;
  logic        ic_valid_o;
  logic [1:0]  ic_beat_o;
  logic        ic_done_o;
  logic        dc_req_i;
  logic        dc_we_i;
  logic [31:0] dc_addr_i;
  logic [31:0] dc_wdata_i;
  logic [31:0] dc_rdata_o;
  logic        dc_valid_o;
  logic [1:0]  dc_beat_o;
  logic        dc_done_o;
  logic        mem_req_o;
  logic        mem_we_o;
  logic [31:0] mem_addr_o;
  logic [31:0] mem_wdata_o;
  logic [31:0] mem_rdata_i;
  logic        mem_ack_i;

  logic [31:0] dc_wline [BEATS];
  assign dc_wdata_i = dc_wline[dc_beat_o];

  mem_arbiter dut (
    .clk_i(clk_i), .rst_n_i(rst_n_i),
    .ic_req_i(ic_req_i), .ic_addr_i(ic_addr_i), .ic_rdata_o(ic_rdata_o),
    .ic_valid_o(ic_valid_o), .ic_beat_o(ic_beat_o), .ic_done_o(ic_done_o),
    .dc_req_i(dc_req_i), .dc_we_i(dc_we_i), .dc_addr_i(dc_addr_i), .dc_wdata_i(dc_wdata_i),
    .dc_rdata_o(dc_rdata_o), .dc_valid_o(dc_valid_o), .dc_beat_o(dc_beat_o), .dc_done_o(dc_done_o),
    .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
    .mem_wdata_o(mem_wdata_o), .mem_rdata_i(mem_rdata_i), .mem_ack_i(mem_ack_i)
  );

  always #5 clk_i = ~clk_i;

  int cyc = 0;
  always @(posedge clk_i) cyc <= cyc + 1;

  typedef struct { logic [31:0] addr; logic we; logic [31:0] wdata; } beat_t;
  typedef struct { logic [31:0] data; logic [1:0] beat; } rd_t;

  beat_t exp_beats[$];
  rd_t   exp_ic[$];
  rd_t   exp_dc[$];
  bit    exp_done[$];   // 0 = icache line, 1 = dcache line

  int n_checks = 0;
  int n_fail   = 0;
  int n_txn    = 0;
  int ic_vcnt  = 0;
  int ack_mode = 0;     // 0 always, 1 random, 2 fixed stall pattern
  bit model_last = 1'b0;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic unexpected(input string name, input logic [31:0] v);
    n_checks++;
    n_fail++;
    $display("FAIL %s: got unexpected event (value %h), expected none (cycle %0d)", name, v, cyc);
  endtask

  // Reference model: a granted line becomes BEATS word accesses from the aligned base.
  task automatic push_line(input bit is_d, input logic [31:0] addr, input bit we);
    logic [31:0] base;
    beat_t b;
    rd_t   r;
    base = addr & ~32'(BEATS * 4 - 1);
    for (int k = 0; k < BEATS; k++) begin
      b.addr  = base + 32'(4 * k);
      b.we    = we;
      b.wdata = we ? dc_wline[k] : 32'h0;
      exp_beats.push_back(b);
      if (!we) begin
        r.data = mem_word(b.addr);
        r.beat = 2'(k);
        if (is_d) exp_dc.push_back(r);
        else      exp_ic.push_back(r);
      end
    end
    exp_done.push_back(is_d);
    model_last = is_d;
  endtask

  task automatic chk_zero(input string tag);
    check({tag, "_ctl"}, 32'({mem_req_o, mem_we_o, ic_valid_o, ic_done_o,
                             dc_valid_o, dc_done_o, ic_beat_o, dc_beat_o}), 32'h0);
    check({tag, "_addr"}, mem_addr_o, 32'h0);
    check({tag, "_wdata"}, mem_wdata_o, 32'h0);
    check({tag, "_rdata"}, ic_rdata_o | dc_rdata_o, 32'h0);
  endtask

  task automatic mem_model();
    int rc = 0;
    bit a;
    forever begin
      @(posedge clk_i);
      #2;
      if (mem_req_o) begin
        rc++;
        case (ack_mode)
          0:       a = 1'b1;
          1:       a = ($urandom_range(0, 2) != 0);
          default: a = (rc == 1 || rc == 4 || rc == 5 || rc == 9);
        endcase
      end else begin
        rc = 0;
        a  = 1'b0;
      end
      mem_ack_i   = a;
      mem_rdata_i = a ? mem_word(mem_addr_o) : $urandom;
    end
  endtask

  task automatic monitor();
    beat_t b;
    rd_t   r;
    bit    d;
    bit    prev_req = 1'b0;
    bit    prev_done = 1'b0;
    int    last_ack = -100;
    forever begin
      @(negedge clk_i);
      if (rst_n_i) begin
        if (mem_req_o && !prev_req) check("grant_gap", 32'(cyc - last_ack >= 2), 32'h1);
        if (!mem_req_o) check("beat_idle", 32'({ic_beat_o, dc_beat_o}), 32'h0);
        if (mem_req_o) begin
          if (exp_beats.size() == 0) begin
            unexpected("mem_req", mem_addr_o);
          end else begin
            check("mem_addr", mem_addr_o, exp_beats[0].addr);
            check("mem_we", 32'(mem_we_o), 32'(exp_beats[0].we));
            if (mem_ack_i) begin
              last_ack = cyc;
              b = exp_beats.pop_front();
              if (b.we) check("mem_wdata", mem_wdata_o, b.wdata);
            end
          end
        end
        if (ic_valid_o) begin
          ic_vcnt++;
          if (exp_ic.size() == 0) unexpected("ic_valid", ic_rdata_o);
          else begin
            r = exp_ic.pop_front();
            check("ic_rdata", ic_rdata_o, r.data);
            check("ic_beat", 32'(ic_beat_o), 32'(r.beat));
          end
        end
        if (dc_valid_o) begin
          if (exp_dc.size() == 0) unexpected("dc_valid", dc_rdata_o);
          else begin
            r = exp_dc.pop_front();
            check("dc_rdata", dc_rdata_o, r.data);
            check("dc_beat", 32'(dc_beat_o), 32'(r.beat));
          end
        end
        if (ic_done_o || dc_done_o) begin
          check("done_pulse", 32'(prev_done), 32'h0);
          check("req_in_done", 32'(mem_req_o), 32'h0);
          if (exp_done.size() == 0) unexpected("done", 32'({dc_done_o, ic_done_o}));
          else begin
            d = exp_done.pop_front();
            check("done_owner", 32'({dc_done_o, ic_done_o}), d ? 32'h2 : 32'h1);
            n_txn++;
            $display("txn %0d: %s line complete at cycle %0d", n_txn, dc_done_o ? "dcache" : "icache", cyc);
          end
        end
        prev_req  = mem_req_o;
        prev_done = ic_done_o | dc_done_o;
      end else begin
        prev_req  = 1'b0;
        prev_done = 1'b0;
      end
    end
  endtask

  task automatic ic_burst(input logic [31:0] a, input bit drop_early);
    bit seen = 1'b0;
    ic_addr_i = a;
    ic_req_i  = 1'b1;
    for (int i = 0; i < 300 && !seen; i++) begin
      @(negedge clk_i);
      if (drop_early && ic_valid_o) ic_req_i = 1'b0;
      if (ic_done_o) seen = 1'b1;
    end
    check("ic_done_timeout", 32'(seen), 32'h1);
    @(posedge clk_i);
    #1;
    ic_req_i = 1'b0;
  endtask

  task automatic dc_burst(input logic [31:0] a, input bit we);
    bit seen = 1'b0;
    dc_addr_i = a;
    dc_we_i   = we;
    dc_req_i  = 1'b1;
    for (int i = 0; i < 300 && !seen; i++) begin
      @(negedge clk_i);
      if (dc_done_o) seen = 1'b1;
    end
    check("dc_done_timeout", 32'(seen), 32'h1);
    @(posedge clk_i);
    #1;
    dc_req_i = 1'b0;
  endtask

  task automatic pair(input logic [31:0] ia, input logic [31:0] da, input bit we);
    bit d_first;
    d_first = RR ? (model_last == 1'b0) : 1'b1;
    if (d_first) begin
      push_line(1'b1, da, we);
      push_line(1'b0, ia, 1'b0);
    end else begin
      push_line(1'b0, ia, 1'b0);
      push_line(1'b1, da, we);
    end
    fork
      ic_burst(ia, 1'b0);
      dc_burst(da, we);
    join
  endtask

  task automatic rand_wline();
    for (int k = 0; k < BEATS; k++) dc_wline[k] = $urandom;
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int  start;
    bit  seen;
    int  kind;
    bit  we;
    logic [31:0] ia, da;

    rst_n_i = 1'b0;
    ic_req_i = 1'b0; ic_addr_i = '0;
    dc_req_i = 1'b0; dc_we_i = 1'b0; dc_addr_i = '0;
    mem_ack_i = 1'b0; mem_rdata_i = '0;
    for (int k = 0; k < BEATS; k++) dc_wline[k] = '0;
    fork
      mem_model();
      monitor();
    join_none

    repeat (3) @(posedge clk_i);
    @(negedge clk_i);
    chk_zero("reset");
    rst_n_i = 1'b1;

    // icache line read, unaligned miss address, ack every cycle, grant latency
    @(posedge clk_i); #1;
    ack_mode = 0;
    push_line(1'b0, 32'h0000_1238, 1'b0);
    fork
      ic_burst(32'h0000_1238, 1'b0);
      begin
        @(negedge clk_i);
        check("lat_before", 32'(mem_req_o), 32'h0);
        @(negedge clk_i);
        check("grant_latency", 32'(mem_req_o), 32'h1);
      end
    join

    // dcache line writeback
    @(posedge clk_i); #1;
    for (int k = 0; k < BEATS; k++) dc_wline[k] = 32'hA0 + 32'(k);
    push_line(1'b1, 32'h0000_2000, 1'b1);
    dc_burst(32'h0000_2000, 1'b1);

    // simultaneous requests, then a dcache-only line, then another tie
    @(posedge clk_i); #1;
    rand_wline();
    pair(32'h0000_4010, 32'h0000_5020, 1'b0);
    @(posedge clk_i); #1;
    push_line(1'b1, 32'h0000_6000, 1'b0);
    dc_burst(32'h0000_6000, 1'b0);
    @(posedge clk_i); #1;
    pair(32'h0000_7000, 32'h0000_8000, 1'b1);

    // ack stalls on request cycles 1, 4, 5, 9
    @(posedge clk_i); #1;
    ack_mode = 2;
    push_line(1'b0, 32'h0000_9008, 1'b0);
    ic_burst(32'h0000_9008, 1'b0);
    ack_mode = 0;

    // reset in the middle of an icache burst
    @(posedge clk_i); #1;
    push_line(1'b0, 32'h0000_3004, 1'b0);
    start = ic_vcnt;
    ic_addr_i = 32'h0000_3004;
    ic_req_i  = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 50 && !seen; i++) begin
      @(negedge clk_i); #1;
      if (ic_vcnt >= start + 2) seen = 1'b1;
    end
    check("rst_wait_beats", 32'(seen), 32'h1);
    #2 rst_n_i = 1'b0;
    #1 chk_zero("async_reset");
    exp_beats.delete(); exp_ic.delete(); exp_dc.delete(); exp_done.delete();
    model_last = 1'b0;
    ic_req_i = 1'b0;
    repeat (2) @(posedge clk_i);
    @(negedge clk_i);
    rst_n_i = 1'b1;
    chk_zero("post_release");
    @(posedge clk_i); #1;
    push_line(1'b0, 32'h0000_3004, 1'b0);
    ic_burst(32'h0000_3004, 1'b0);

    // request dropped after the first beat still completes the line
    @(posedge clk_i); #1;
    push_line(1'b0, 32'h0000_A00C, 1'b0);
    ic_burst(32'h0000_A00C, 1'b1);

    // randomized traffic under random ack back-pressure
    for (int n = 0; n < 30; n++) begin
      @(posedge clk_i); #1;
      ack_mode = $urandom_range(0, 1);
      kind = $urandom_range(0, 2);
      ia = $urandom;
      da = $urandom;
      we = 1'($urandom_range(0, 1));
      rand_wline();
      case (kind)
        0: begin
          push_line(1'b0, ia, 1'b0);
          ic_burst(ia, 1'($urandom_range(0, 1)));
        end
        1: begin
          push_line(1'b1, da, we);
          dc_burst(da, we);
        end
        default: pair(ia, da, we);
      endcase
    end

    repeat (4) @(posedge clk_i);
    @(negedge clk_i); #1;
    check("sb_drained", 32'(exp_beats.size() + exp_ic.size() + exp_dc.size() + exp_done.size()), 32'h0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
